// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//
// A clock divider produces a pixel advance strobe from clk. On each advance
// the horizontal counter steps and wraps, and the vertical counter steps on
// each horizontal wrap. Every output is a register loaded from the *next*
// counter values, so the markers line up with the counter values shown
// alongside them.
//
// Ports:
//   clk          system clock (single domain)
//   reset        asynchronous, active-high reset
//   enable       advance enable; low freezes counters, divider and levels
//   pix_stb      one-clk pulse on every pixel advance
//   hcount       current horizontal position   [CNT_W-1:0]
//   vcount       current vertical position     [CNT_W-1:0]
//   hsync        horizontal sync, asserted level = HS_POL
//   vsync        vertical sync, asserted level = VS_POL
//   de           data enable (inside the visible area)
//   line_start   one-clk pulse when hcount becomes 0
//   frame_start  one-clk pulse when (hcount,vcount) becomes (0,0)
//   frame_cnt    frames started since reset, wraps  [FRAME_W-1:0]
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               pix_stb,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Decode comparisons use one extra bit so that boundaries equal to
    // 2^CNT_W (no porches) are still representable.
    localparam int unsigned XW      = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG_X = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END_X = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] V_ACT_X  = XW'(V_ACTIVE);
    localparam logic [XW-1:0] VS_BEG_X = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0] VS_END_X = XW'(V_ACTIVE + V_FP + V_SYNC);

    // Reject parameter sets the counters cannot represent.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((longint'(H_TOTAL) - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
    end
    if ((longint'(V_TOTAL) - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
    end

    // State registers
    logic [DIV_W-1:0]   div_q,         div_d;
    logic [CNT_W-1:0]   hcount_q,      hcount_d;
    logic [CNT_W-1:0]   vcount_q,      vcount_d;
    logic               pix_stb_q,     pix_stb_d;
    logic               hsync_q,       hsync_d;
    logic               vsync_q,       vsync_d;
    logic               de_q,          de_d;
    logic               line_start_q,  line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q,   frame_cnt_d;

    logic          adv;
    logic [XW-1:0] hx;
    logic [XW-1:0] vx;
    logic          h_in_sync;
    logic          v_in_sync;

    // Divider and raster counters.
    always_comb begin
        div_d    = div_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        adv      = enable && (div_q == '0);

        if (adv) begin
            div_d = DIV_RELOAD;
        end else if (enable) begin
            div_d = div_q - DIV_W'(1);
        end

        if (adv) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end
    end

    // Output decode from the next counter values; with enable low the next
    // values equal the current ones, so the levels simply hold.
    always_comb begin
        hx        = {1'b0, hcount_d};
        vx        = {1'b0, vcount_d};
        h_in_sync = (hx >= HS_BEG_X) && (hx < HS_END_X);
        v_in_sync = (vx >= VS_BEG_X) && (vx < VS_END_X);

        pix_stb_d     = adv;
        de_d          = (hx < H_ACT_X) && (vx < V_ACT_X);
        hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
        vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
        line_start_d  = adv && (hcount_d == '0);
        frame_start_d = line_start_d && (vcount_d == '0);
        frame_cnt_d   = frame_start_d ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
    end

    // Reset parks the raster on the last blanking position so the first
    // advance wraps straight into (0,0) and opens frame 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            pix_stb_q     <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pix_stb_q     <= pix_stb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_stb     = pix_stb_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 horizontal/vertical counter. It derives a pixel strobe from the system clock, runs horizontal and vertical counters of configurable width, and drives registered sync, data-enable and frame/line markers, all cycle-aligned to the counters. Sync polarity, timing set and divider ratio are parameters. It sits between the system clock domain and the pixel pipeline (frame buffer reader / UART-fed text renderer) that consumes `hcount`/`vcount`/`de`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 4, clk cycles per pixel, >= 1
- `HS_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VS_POL`, 0, asserted level of `vsync`
- `CNT_W`, 10, width of `hcount`/`vcount`; must hold H_TOTAL-1 and V_TOTAL-1
- `FRAME_W`, 8, width of `frame_cnt`

- `clk` in 1 system clock; single clock domain
- `reset` in 1 asynchronous, active-high reset
- `enable` in 1 advance enable; low freezes all state
- `pix_stb` out 1 one-clk pulse; outputs updated this edge
- `hcount` out CNT_W current horizontal position
- `vcount` out CNT_W current vertical position
- `hsync` out 1 horizontal sync, level per `HS_POL`
- `vsync` out 1 vertical sync, level per `VS_POL`
- `de` out 1 high when hcount < H_ACTIVE and vcount < V_ACTIVE
- `line_start` out 1 one-clk pulse when hcount becomes 0
- `frame_start` out 1 one-clk pulse when (hcount,vcount) becomes (0,0)
- `frame_cnt` out FRAME_W frames started since reset, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if CLK_DIV < 1 or H_TOTAL-1 / V_TOTAL-1 exceed 2^CNT_W-1.
- Divider `div_cnt` (width clog2(CLK_DIV), min 1): internal strobe `adv` = enable && div_cnt == 0. On `adv` reload CLK_DIV-1; else if enable decrement; else hold. CLK_DIV = 1: `adv` = enable.
- On `adv`: hcount = (hcount == H_TOTAL-1) ? 0 : hcount+1; on horizontal wrap, vcount = (vcount == V_TOTAL-1) ? 0 : vcount+1.
- All outputs are registers decoded from the next counter values, so they describe the new (hcount,vcount) on the edge it appears. No combinational path from inputs to outputs.
- hsync asserted when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vsync asserted when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; deasserted level = inverse of polarity.
- `frame_cnt` increments (mod 2^FRAME_W) on the edge `frame_start` rises.
- `pix_stb`, `line_start`, `frame_start` are high exactly one clk; low on every clk without `adv`.

## Timing
- Reset values: hcount = H_TOTAL-1, vcount = V_TOTAL-1 (last blanking position), div_cnt = 0, de = 0, hsync = !HS_POL, vsync = !VS_POL, pix_stb = line_start = frame_start = 0, frame_cnt = 0.
- First enabled clk after reset release is an `adv`: counters wrap to (0,0); pix_stb, line_start, frame_start, de all 1; frame_cnt = 1.
- Steady state with enable high: one `adv` every CLK_DIV clks; one line per H_TOTAL*CLK_DIV clks; one frame per H_TOTAL*V_TOTAL*CLK_DIV clks.
- enable low: counters, div_cnt, levels (hsync, vsync, de) hold; pulses drop after one clk. On re-enable, next `adv` occurs after the preserved div_cnt counts down.
- Reset asserted mid-frame: all outputs take reset values immediately, without waiting for a clk edge; deassertion resumes as above.
- Simultaneous horizontal and vertical wrap: both applied on the same edge; frame_start and line_start both pulse.

## Test plan
- Defaults, reset release, enable high -> clk 1: hcount=0, vcount=0, de=1, line_start=frame_start=pix_stb=1, frame_cnt=1; hcount=1 exactly 4 clks later; pix_stb period 4.
- Sweep one line -> de=0 from hcount 640 to 799; hsync=0 for hcount 656..751, 1 at 655 and 752; line_start at hcount 0 each 3200 clks.
- Full frame -> vsync=0 only for vcount 490..491; frame_start every 1,680,000 clks; frame_cnt 1->2; FRAME_W=2 wraps 3->0.
- enable low for 10 clks at hcount=100 -> all levels held, no pulses; hcount=101 on first `adv` after re-enable, timed by preserved div_cnt.
- Async reset pulse between clk edges mid-frame -> outputs at reset values before the next edge; restart identical to scenario 1.
- H=4/1/1/1, V=2/1/1/1, CLK_DIV=1, HS_POL=VS_POL=1, CNT_W=3 -> hcount wraps 0..6, vcount 0..4; hsync=1 only at hcount 5; vsync=1 only at vcount 3; frame period 35 clks.
